// File: rtl/dff_pkg.sv
// Shared constants and types for the D flip-flop family.
`timescale 1ns/1ps
package dff_pkg;

  localparam int DFF_MAX_WIDTH = 64;

  typedef logic [DFF_MAX_WIDTH-1:0] dff_rst_val_t;

  localparam dff_rst_val_t DFF_RST_DEFAULT = '0;

endpackage

// File: rtl/dff_bit_cell.sv
// Single storage bit, rising-edge capture, async active-low reset.
`timescale 1ns/1ps
module dff_bit_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = d_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/flip_flop_d_rise.sv
// WIDTH-bit rising-edge D register with async active-low reset
// and complementary output.
`timescale 1ns/1ps
module flip_flop_d_rise
  import dff_pkg::*;
#(
  parameter int           WIDTH       = 1,
  parameter dff_rst_val_t RESET_VALUE = DFF_RST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_bad_width
    $error("flip_flop_d_rise: WIDTH %0d outside 1..%0d",
           WIDTH, DFF_MAX_WIDTH);
  end

  logic [WIDTH-1:0] q_w;

  // Bits are fully independent; each cell carries its own reset bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit_cell #(
      .RST_VAL (RESET_VALUE[i])
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (D[i]),
      .q_o   (q_w[i])
    );
  end

  assign Q  = q_w;
  assign Qn = ~q_w;

endmodule

// File: tb/tb_flip_flop_d_rise.sv
// Scoreboard bench for flip_flop_d_rise: four instances, directed vectors.
`timescale 1ns/1ps
module tb_flip_flop_d_rise;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rst2, rst3;
  logic       d0, d1;
  logic [7:0] d2, d3;
  logic       q0, qn0, q1, qn1;
  logic [7:0] q2, qn2, q3, qn3;

  flip_flop_d_rise #(.WIDTH(1)) u_a (
    .clk(clk), .rst_n(rst0), .D(d0), .Q(q0), .Qn(qn0)
  );

  flip_flop_d_rise #(.WIDTH(1)) u_b (
    .clk(clk), .rst_n(rst1), .D(d1), .Q(q1), .Qn(qn1)
  );

  flip_flop_d_rise #(.WIDTH(8), .RESET_VALUE(64'hA5)) u_c (
    .clk(clk), .rst_n(rst2), .D(d2), .Q(q2), .Qn(qn2)
  );

  flip_flop_d_rise #(.WIDTH(8)) u_d (
    .clk(clk), .rst_n(rst3), .D(d3), .Q(q3), .Qn(qn3)
  );

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic [7:0] qn;
    real        due;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;
  int   q3_chg = 0;

  // Count Q transitions of u_d around the mid-operation reset.
  always @(q3) begin
    if ($time > 16 && $time < 30) q3_chg++;
  end

  task automatic push(input int dut, input logic [7:0] q,
                      input real due, input string name);
    exp_t e;
    e.dut  = dut;
    e.q    = q;
    e.qn   = ~q;
    e.due  = due;
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic real sync_due();
    longint t;
    t = longint'($time);
    if (t < 5) return 5.5;
    return real'(5 + 10 * ((t - 5) / 10 + 1)) + 0.5;
  endfunction

  task automatic compare(input exp_t e);
    logic [7:0] aq, aqn, m;
    aq = '0; aqn = '0; m = 8'hFF;
    case (e.dut)
      0: begin aq = {7'b0, q0}; aqn = {7'b0, qn0}; m = 8'h01; end
      1: begin aq = {7'b0, q1}; aqn = {7'b0, qn1}; m = 8'h01; end
      2: begin aq = q2; aqn = qn2; end
      3: begin aq = q3; aqn = qn3; end
      default: begin aq = q3_chg[7:0]; aqn = ~q3_chg[7:0]; end
    endcase
    checks++;
    if ((aq & m) !== (e.q & m)) begin
      errs++;
      $display("FAIL %s Q: got %h expected %h at %0t",
               e.name, aq & m, e.q & m, $time);
    end
    if (e.dut != 4) begin
      checks++;
      if ((aqn & m) !== (e.qn & m)) begin
        errs++;
        $display("FAIL %s Qn: got %h expected %h at %0t",
                 e.name, aqn & m, e.qn & m, $time);
      end
    end
  endtask

  // Monitor samples half a unit off the integer grid, away from edges.
  initial begin
    #0.5;
    forever begin
      int i;
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due <= $realtime) begin
          compare(sb[i]);
          sb.delete(i);
        end else begin
          i++;
        end
      end
      #1;
    end
  end

  initial begin
    fork
      begin
        d0 = 1'b1; rst0 = 1'b1;
        #3 rst0 = 1'b0;
        push(0, 8'h00, 3.5, "a_rst_async");
        #1 push(0, 8'h00, 5.5, "a_rst_edge5");
        #3 rst0 = 1'b1; d0 = 1'b0;
        #3 push(0, {7'b0, d0}, sync_due(), "a_cap15");
        repeat (3) begin
          @(posedge clk);
          d0 <= ~d0;
          push(0, {7'b0, ~d0}, sync_due(), "a_cap_toggle");
        end
        @(posedge clk);
        d0 <= ~d0;
      end
      begin
        rst1 = 1'b0; d1 = 1'b1;
        #1;
        push(1, 8'h00, 5.5, "b_rst_edge5");
        push(1, 8'h00, 15.5, "b_rst_edge15");
        #16 rst1 = 1'b1;
        push(1, 8'h00, 17.5, "b_release");
        push(1, 8'h00, 24.5, "b_hold_to_edge");
        push(1, 8'h01, 25.5, "b_first_cap");
      end
      begin
        rst2 = 1'b1; d2 = 8'h00;
        #2 rst2 = 1'b0;
        push(2, 8'hA5, 2.5, "c_rst_val");
        #2 rst2 = 1'b1; d2 = 8'h3C;
        push(2, 8'hA5, 4.5, "c_release_hold");
        push(2, 8'h3C, 5.5, "c_cap");
        #12 d2 = 8'h11;
        #2  d2 = 8'h22;
        #2  d2 = 8'h77;
        #2  d2 = 8'h96;
        push(2, 8'h3C, 22.5, "c_hold");
        push(2, 8'h96, 25.5, "c_hold_cap");
      end
      begin
        rst3 = 1'b1; d3 = 8'hFF;
        #1 rst3 = 1'b0;
        #2 rst3 = 1'b1;
        push(3, 8'hFF, 5.5, "d_cap_ff");
        #14 rst3 = 1'b0;
        push(3, 8'h00, 17.5, "d_mid_rst");
        push(3, 8'h00, 25.5, "d_rst_hold");
        push(4, 8'h01, 29.5, "d_no_glitch");
        #15 rst3 = 1'b1;
      end
    join
    #10;
    while (sb.size() > 0) begin
      errs++;
      $display("FAIL %s unchecked: got none expected compare",
               sb[0].name);
      sb.delete(0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
